// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed N-digit 7-segment driver.
// The input word is snapshotted once per frame, each slot opens with an
// anti-ghosting blank window, and all outputs are registered (1-cycle latency).
// Optional feature macro SEG7_DIM_EN adds a brightness input with 16-step PWM dimming.
module seg7_scan_mux #(
  parameter int unsigned N_DIGITS     = 8,
  parameter int unsigned DIV          = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned ACTIVE_LOW   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] hex_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   digit_en,
`ifdef SEG7_DIM_EN
  input  logic [3:0]            brightness,
`endif
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   anodes,
  output logic                  frame_start
);

  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic             OFF       = (ACTIVE_LOW != 0);

  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [N_DIGITS-1:0][3:0]     shadow_hex_q, shadow_hex_d;
  logic [N_DIGITS-1:0]          shadow_dp_q, shadow_dp_d;
  logic [N_DIGITS-1:0]          shadow_en_q, shadow_en_d;
  logic                         init_q, init_d;
  logic [6:0]                   seg_q, seg_d;
  logic                         dp_q, dp_d;
  logic [N_DIGITS-1:0]          an_q, an_d;
  logic                         fs_q, fs_d;
  logic                         load_c;
  logic                         lit_c;
`ifdef SEG7_DIM_EN
  logic [3:0]                   pwm_q, pwm_d;
  logic [3:0]                   bright_q, bright_d;
`endif

  // Active-high gfedcba glyph for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'b0111111;
      4'h1:    s = 7'b0000110;
      4'h2:    s = 7'b1011011;
      4'h3:    s = 7'b1001111;
      4'h4:    s = 7'b1100110;
      4'h5:    s = 7'b1101101;
      4'h6:    s = 7'b1111101;
      4'h7:    s = 7'b0000111;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1101111;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b1111100;
      4'hC:    s = 7'b0111001;
      4'hD:    s = 7'b1011110;
      4'hE:    s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  // Next-state: slot prescaler, digit index, frame snapshot and output drive.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    // Load at the last cycle of a frame, or straight away after reset.
    load_c       = init_q || ((cnt_q == CNT_LAST) && (idx_q == IDX_LAST));
    shadow_hex_d = load_c ? hex_in   : shadow_hex_q;
    shadow_dp_d  = load_c ? dp_in    : shadow_dp_q;
    shadow_en_d  = load_c ? digit_en : shadow_en_q;
    // init always triggers a load, so it is cleared after its first cycle.
    init_d       = 1'b0;

    lit_c = (cnt_q >= CNT_BLANK) && shadow_en_q[idx_q];
`ifdef SEG7_DIM_EN
    pwm_d    = pwm_q + 4'd1;
    bright_d = load_c ? brightness : bright_q;
    lit_c    = lit_c && (pwm_q <= bright_q);
`endif

    seg_d = (lit_c ? seg_decode(shadow_hex_q[idx_q]) : 7'd0) ^ {7{OFF}};
    dp_d  = (lit_c & shadow_dp_q[idx_q]) ^ OFF;
    an_d  = (lit_c ? (N_DIGITS'(1) << idx_q) : '0) ^ {N_DIGITS{OFF}};
    fs_d  = load_c;
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_hex_q <= '0;
      shadow_dp_q  <= '0;
      shadow_en_q  <= '0;
      init_q       <= 1'b1;
      seg_q        <= {7{OFF}};
      dp_q         <= OFF;
      an_q         <= {N_DIGITS{OFF}};
      fs_q         <= 1'b0;
`ifdef SEG7_DIM_EN
      pwm_q        <= '0;
      bright_q     <= 4'hF;
`endif
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_hex_q <= shadow_hex_d;
      shadow_dp_q  <= shadow_dp_d;
      shadow_en_q  <= shadow_en_d;
      init_q       <= init_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      fs_q         <= fs_d;
`ifdef SEG7_DIM_EN
      pwm_q        <= pwm_d;
      bright_q     <= bright_d;
`endif
    end
  end

  assign segments    = seg_q;
  assign dp          = dp_q;
  assign anodes      = an_q;
  assign frame_start = fs_q;

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
Parametrised time-multiplexed driver for an N-digit common-anode/cathode 7-segment display.
- Scans digits at a programmable slot rate.
- Latches the input word once per frame so digits within a frame never mix old and new values.
- Inserts an anti-ghosting blank interval at the start of each slot.
- Supports per-digit enable and decimal points.
- Sits between the datapath's packed hex word and the board display pins.

Parameters:
N_DIGITS, 8, number of digits; legal range 1..16
DIV, 100000, clock cycles per digit slot; must be >= 2
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must be < DIV
ACTIVE_LOW, 1, 1 = anodes/segments/dp driven active-low; 0 = active-high

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
hex_in  in  4*N_DIGITS  nibble k drives digit k (digit 0 = bits 3:0)
dp_in  in  N_DIGITS  decimal point request per digit
digit_en  in  N_DIGITS  1 = digit lit; 0 = digit dark (slot time still consumed)
segments  out  7  gfedcba order, bit 0 = a
dp  out  1  decimal point of current digit
anodes  out  N_DIGITS  one-hot (in active polarity) digit select
frame_start  out  1  one-cycle pulse when a new frame snapshot is loaded

Behaviour:
- Reset is synchronous, active-high, on clock; clock is the only clock.
- State registers:
  - cnt: 0..DIV-1, slot prescaler.
  - idx: 0..N_DIGITS-1, digit index.
  - shadow_hex, shadow_dp, shadow_en: frame snapshot.
  - init: one-bit flag.
- Reset values:
  - cnt=0, idx=0, all shadows=0, init=1.
  - anodes all inactive, segments all off, dp off (all 1s when ACTIVE_LOW=1, all 0s otherwise).
  - frame_start=0.
- Counting:
  - Each cycle, cnt increments.
  - When cnt==DIV-1: cnt wraps to 0 and idx advances; idx wraps from N_DIGITS-1 to 0.
- Snapshot load condition: (cnt==DIV-1 and idx==N_DIGITS-1) or init==1.
  - On load: shadow_* <= hex_in, dp_in, digit_en; init <= 0; frame_start pulses high for exactly one cycle (registered, visible in the next cycle).
  - The first cycle after reset release therefore loads immediately, so there is no dark frame.
- Output stage is registered: outputs in cycle t+1 are a function of cnt, idx and shadow_* in cycle t. Fixed latency is 1 cycle.
- Anode for idx is active iff cnt >= BLANK_CYCLES and shadow_en[idx]==1. All other anodes are inactive.
- Segment decode of shadow_hex[idx], in active-high gfedcba:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
- segments and dp are forced to off whenever the anode is inactive (blank window or disabled digit).
- dp = shadow_dp[idx] when lit.
- ACTIVE_LOW=1 inverts anodes, segments and dp at the output register.
- Changes to hex_in, dp_in or digit_en mid-frame have no visible effect until the next frame load.
- Frame period is exactly N_DIGITS*DIV cycles. frame_start pulses are that far apart.
- Reset mid-frame:
  - The next cycle returns to the reset values.
  - Scanning restarts at digit 0, cnt=0, with an immediate snapshot load on the first non-reset cycle.
- N_DIGITS=1: idx stays 0, and every slot wrap is a frame boundary.

Optional Feature:
SEG7_DIM_EN
- Defined:
  - Adds input port brightness[3:0].
  - Adds a free-running 4-bit counter pwm; reset 0; increments every cycle; wraps 15→0.
  - An otherwise-active anode is lit only while pwm <= brightness_shadow.
  - brightness_shadow is loaded with the other shadows at frame load (reset 4'hF).
  - brightness=15 gives full on; brightness=0 gives 1/16 duty.
  - When not lit, segments and dp are off.
- Undefined: no brightness port and no pwm counter; behaviour is exactly as in Behaviour above.

Test Plan:
(Bench uses N_DIGITS=4, DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=1.)
1. Hold reset 3 cycles → anodes=4'b1111, segments=7'b1111111, dp=1, frame_start=0. First cycle after release → frame_start=1 in the following cycle.
2. hex_in=16'h3210, digit_en=4'hF, dp_in=0 → slot 0, cnt 2..7: anodes=4'b1110, segments=7'b1000000. Slot 1: anodes=4'b1101, segments=7'b1111001. cnt 0..1 of each slot: anodes=4'b1111.
3. Tear-free check: during slot 1, drive hex_in=16'hFFFF → slots 2 and 3 still show 2 (7'b0100100) and 3 (7'b0110000). After the next frame_start, all slots show F (7'b0001110).
4. digit_en=4'b0101, dp_in=4'b0001 → slots 1 and 3: anodes=4'b1111 and segments all 1 for the whole slot. Slot 0: dp=0. Slot period stays 8 cycles.
5. Free-run 200 cycles → frame_start pulses exactly every 32 cycles. Assert reset during slot 2 → next frame starts at slot 0, and frame_start fires on the first post-reset cycle.
6. With SEG7_DIM_EN: brightness=0 → within an active window, the anode is low only on cycles where pwm==0. brightness=15 → identical to test 2.
